player_move_ctrl: RTL

Turns raw left/right button levels into paced single-cycle step pulses for the player position register: a tap gives one step, and holding a button auto-repeats.
- Front end per button: synchronizer plus debounce.
- Core: a hold/auto-repeat state machine that also resolves conflicting buttons.
- Sits between the board buttons and the player position datapath; the step pulses drive that datapath's move-left/move-right inputs.

---
 rtl/game_pkg.sv | 39 +++
 rtl/btn_debounce.sv | 65 ++++++
 rtl/player_move_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared types and default timing for the player movement front end.
//   move_state_e : hold/auto-repeat FSM state encoding
//   move_dir_e   : direction request / latched direction encoding
//   DEF_*        : default timing constants used as parameter defaults
//   dir_request  : maps debounced button levels to a direction request;
//                  both pressed is treated as neutral (NONE)
// ---------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_HOLD_DELAY = 2'd1,
    ST_REPEAT     = 2'd2
  } move_state_e;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } move_dir_e;

  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_DEBOUNCE_CYC = 50000;
  localparam int DEF_REPEAT_DELAY = 12500000;
  localparam int DEF_REPEAT_RATE  = 2500000;
  localparam int DEF_ACCEL_AFTER  = 8;
  localparam int DEF_CNT_W        = 24;

  function automatic move_dir_e dir_request(input logic left, input logic right);
    case ({left, right})
      2'b10:   dir_request = DIR_LEFT;
      2'b01:   dir_request = DIR_RIGHT;
      default: dir_request = DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Synchronizes one raw, asynchronous button level into i_Clk and debounces
// it: the debounced level only follows the synchronized level after
// DEBOUNCE_CYC consecutive cycles of disagreement.
// Ports:
//   i_Clk     : system clock
//   i_Rst     : asynchronous, active-high reset (all state to 0)
//   i_btn_raw : raw button level, asynchronous to i_Clk
//   o_level   : debounced level (registered)
// ---------------------------------------------------------------------------
module btn_debounce
  import game_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_btn_raw,
  output logic o_level
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q, level_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sync_level;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign sync_level = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], i_btn_raw};
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync_level == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
      // DEBOUNCE_CYC consecutive disagreeing samples seen: accept new level
      level_d = sync_level;
      cnt_d   = '0;
    end else begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_level = level_q;

endmodule

// File: rtl/player_move_ctrl.sv
// ---------------------------------------------------------------------------
// player_move_ctrl
// Converts raw left/right button levels into paced single-cycle step pulses
// for the player position datapath. A tap gives one step; holding a button
// gives a first step, then after REPEAT_DELAY cycles auto-repeat steps every
// REPEAT_RATE cycles. Both buttons pressed is neutral.
//
// Build option:
//   MOVE_ACCEL_EN : when defined, after ACCEL_AFTER repeat pulses in REPEAT
//                   the repeat interval drops to max(REPEAT_RATE/2, 1) until
//                   REPEAT is left. When undefined no accel counter exists.
//
// Ports:
//   i_Clk        : system clock
//   i_Rst        : asynchronous, active-high reset
//   i_btn_Left   : raw left button level (asynchronous)
//   i_btn_Right  : raw right button level (asynchronous)
//   i_enable     : movement enable; 0 forces IDLE and suppresses steps
//   o_step_Left  : one-cycle pulse, move left by one
//   o_step_Right : one-cycle pulse, move right by one
//   o_active     : high while in HOLD_DELAY or REPEAT
// ---------------------------------------------------------------------------
module player_move_ctrl
  import game_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter int ACCEL_AFTER  = DEF_ACCEL_AFTER,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_btn_Left,
  input  logic i_btn_Right,
  input  logic i_enable,
  output logic o_step_Left,
  output logic o_step_Right,
  output logic o_active
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYC < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
      ACCEL_AFTER < 1 || (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYC) ||
      (64'd1 << CNT_W) <= 64'(REPEAT_DELAY)) begin : g_param_check
    $error("player_move_ctrl: illegal parameter combination");
  end

  logic             deb_left, deb_right;
  move_dir_e        req;
  move_state_e      state_q, state_d;
  move_dir_e        dir_q, dir_d;
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [CNT_W-1:0] interval_m1;
  logic             step_left_q, step_left_d;
  logic             step_right_q, step_right_d;
  logic             active_q, active_d;
  logic             pulse;
  move_dir_e        pulse_dir;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  btn_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .CNT_W       (CNT_W)
  ) u_deb_left (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_btn_raw(i_btn_Left),
    .o_level  (deb_left)
  );

  btn_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .CNT_W       (CNT_W)
  ) u_deb_right (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_btn_raw(i_btn_Right),
    .o_level  (deb_right)
  );

  assign req = dir_request(deb_left, deb_right);

`ifdef MOVE_ACCEL_EN
  localparam int FAST_RATE = (REPEAT_RATE / 2 > 1) ? REPEAT_RATE / 2 : 1;
  localparam int ACC_W     = $clog2(ACCEL_AFTER + 1);

  logic [ACC_W-1:0] acc_q, acc_d;

  assign interval_m1 = (acc_q >= ACC_W'(ACCEL_AFTER)) ? CNT_W'(FAST_RATE - 1)
                                                      : CNT_W'(REPEAT_RATE - 1);

  // Counts pulses issued from REPEAT; saturates at ACCEL_AFTER, clears on IDLE
  always_comb begin
    acc_d = acc_q;
    if (state_d == ST_IDLE) begin
      acc_d = '0;
    end else if (state_q == ST_REPEAT && pulse && acc_q < ACC_W'(ACCEL_AFTER)) begin
      acc_d = acc_q + ACC_W'(1);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  assign interval_m1 = CNT_W'(REPEAT_RATE - 1);
`endif

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    rpt_cnt_d = rpt_cnt_q;
    pulse     = 1'b0;
    pulse_dir = dir_q;

    case (state_q)
      ST_IDLE: begin
        rpt_cnt_d = '0;
        if (i_enable && req != DIR_NONE) begin
          pulse     = 1'b1;
          pulse_dir = req;
          dir_d     = req;
          state_d   = ST_HOLD_DELAY;
        end
      end

      ST_HOLD_DELAY: begin
        // Release, opposite press or both pressed all leave without a pulse
        if (!i_enable || req != dir_q) begin
          state_d   = ST_IDLE;
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
          pulse     = 1'b1;
          rpt_cnt_d = '0;
          state_d   = ST_REPEAT;
        end else begin
          rpt_cnt_d = sat_inc(rpt_cnt_q);
        end
      end

      ST_REPEAT: begin
        if (!i_enable || req != dir_q) begin
          state_d   = ST_IDLE;
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q >= interval_m1) begin
          // >= so a drop to the faster interval never skips past the match
          pulse     = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = sat_inc(rpt_cnt_q);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        rpt_cnt_d = '0;
      end
    endcase

    step_left_d  = pulse && (pulse_dir == DIR_LEFT);
    step_right_d = pulse && (pulse_dir == DIR_RIGHT);
    active_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q      <= ST_IDLE;
      dir_q        <= DIR_LEFT;
      rpt_cnt_q    <= '0;
      step_left_q  <= 1'b0;
      step_right_q <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      rpt_cnt_q    <= rpt_cnt_d;
      step_left_q  <= step_left_d;
      step_right_q <= step_right_d;
      active_q     <= active_d;
    end
  end

  assign o_step_Left  = step_left_q;
  assign o_step_Right = step_right_q;
  assign o_active     = active_q;

endmodule
